// File: rtl/hack_memory_if.sv
// Bus bundle between the Hack CPU/program-loader side and hack_memory.
// The memory side uses the slave modport; the CPU/loader side uses master.
interface hack_memory_if;
  logic [15:0] i_pc;
  logic [15:0] o_instruction;
  logic [15:0] i_ramaddr;
  logic [15:0] i_ram_data;
  logic        i_ram_write;
  logic [15:0] o_ram;
  logic        o_cpu_reset;
  logic        i_load_valid;
  logic [7:0]  i_load_byte;
  logic        o_load_ready;
  logic        i_reload;
  logic [15:0] i_keyboard;
  logic [15:0] o_led;
  logic        o_loaded;
  logic        o_load_error;

  modport master (
    output i_pc, i_ramaddr, i_ram_data, i_ram_write,
    output i_load_valid, i_load_byte, i_reload, i_keyboard,
    input  o_instruction, o_ram, o_cpu_reset, o_load_ready,
    input  o_led, o_loaded, o_load_error
  );

  modport slave (
    input  i_pc, i_ramaddr, i_ram_data, i_ram_write,
    input  i_load_valid, i_load_byte, i_reload, i_keyboard,
    output o_instruction, o_ram, o_cpu_reset, o_load_ready,
    output o_led, o_loaded, o_load_error
  );
endinterface

// File: rtl/hack_memory.sv
// Hack computer memory: byte-stream-loaded instruction ROM, data RAM and keyboard/LED I/O.
// Define HACK_MEM_LOAD_CHECKSUM_EN to require a trailing XOR checksum byte on each load.
module hack_memory #(
  parameter int ROM_DEPTH = 1024,
  parameter int RAM_DEPTH = 1024
) (
  input logic          clk,
  input logic          i_reset,
  hack_memory_if.slave bus
);
  localparam int          ROM_AW    = $clog2(ROM_DEPTH);
  localparam int          RAM_AW    = $clog2(RAM_DEPTH);
  localparam logic [16:0] ROM_LIMIT = 17'(ROM_DEPTH);
  localparam logic [16:0] RAM_LIMIT = 17'(RAM_DEPTH);
  localparam logic [15:0] KBD_ADDR  = 16'h6000;
  localparam logic [15:0] LED_ADDR  = 16'h6001;

`ifdef HACK_MEM_LOAD_CHECKSUM_EN
  typedef enum logic [2:0] {
    HDR_HI  = 3'd0,
    HDR_LO  = 3'd1,
    WORD_HI = 3'd2,
    WORD_LO = 3'd3,
    CHECK   = 3'd4,
    RUN     = 3'd5,
    ERROR   = 3'd6
  } state_t;
  localparam state_t LOAD_END = CHECK;
`else
  typedef enum logic [2:0] {
    HDR_HI  = 3'd0,
    HDR_LO  = 3'd1,
    WORD_HI = 3'd2,
    WORD_LO = 3'd3,
    RUN     = 3'd5,
    ERROR   = 3'd6
  } state_t;
  localparam state_t LOAD_END = RUN;
`endif

  state_t      state;
  state_t      next_state;
  logic [15:0] rom [ROM_DEPTH];
  logic [15:0] ram [RAM_DEPTH];
  logic [7:0]  hi_byte;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic [15:0] led;
  logic        cpu_reset;
  logic        load_ready;
  logic        loaded;
  logic        accept;
  logic        last_word;
  logic        rom_we;
  logic        cpu_write;
  logic [15:0] ram_rd;
`ifdef HACK_MEM_LOAD_CHECKSUM_EN
  logic [7:0]  csum;
  logic        load_error;
`endif

  assign accept    = bus.i_load_valid & load_ready;
  assign last_word = (word_idx == (n_words - 16'd1));
  // Words past the end of the ROM are swallowed rather than wrapped onto low addresses.
  assign rom_we    = accept && (state == WORD_LO) && ({1'b0, word_idx} < ROM_LIMIT);
  assign cpu_write = bus.i_ram_write & ~cpu_reset;

  // Next-state decode for the loader FSM.
  always_comb begin
    next_state = state;
    case (state)
      HDR_HI:  if (accept) next_state = HDR_LO;  else next_state = state;
      HDR_LO: begin
        if (accept) begin
          if ({hi_byte, bus.i_load_byte} == 16'h0000) next_state = LOAD_END;
          else                                        next_state = WORD_HI;
        end else begin
          next_state = state;
        end
      end
      WORD_HI: if (accept) next_state = WORD_LO; else next_state = state;
      WORD_LO: begin
        if (accept) begin
          if (last_word) next_state = LOAD_END;
          else           next_state = WORD_HI;
        end else begin
          next_state = state;
        end
      end
`ifdef HACK_MEM_LOAD_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          if (bus.i_load_byte == csum) next_state = RUN;
          else                         next_state = ERROR;
        end else begin
          next_state = state;
        end
      end
`endif
      RUN, ERROR: if (bus.i_reload) next_state = HDR_HI; else next_state = state;
      default: next_state = HDR_HI;
    endcase
  end

  // Loader FSM state, byte/word bookkeeping and registered status outputs.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state      <= HDR_HI;
      hi_byte    <= 8'h00;
      n_words    <= 16'h0000;
      word_idx   <= 16'h0000;
      cpu_reset  <= 1'b1;
      load_ready <= 1'b1;
      loaded     <= 1'b0;
`ifdef HACK_MEM_LOAD_CHECKSUM_EN
      csum       <= 8'h00;
      load_error <= 1'b0;
`endif
    end else begin
      state      <= next_state;
      cpu_reset  <= (next_state != RUN);
      load_ready <= (next_state != RUN) && (next_state != ERROR);
      loaded     <= (next_state == RUN);
`ifdef HACK_MEM_LOAD_CHECKSUM_EN
      load_error <= (next_state == ERROR);
      if (accept) csum <= (state == HDR_HI) ? bus.i_load_byte : (csum ^ bus.i_load_byte);
`endif
      if ((state == RUN || state == ERROR) && bus.i_reload) word_idx <= 16'h0000;
      if (accept) begin
        case (state)
          HDR_HI: begin
            hi_byte  <= bus.i_load_byte;
            word_idx <= 16'h0000;
          end
          HDR_LO:  n_words  <= {hi_byte, bus.i_load_byte};
          WORD_HI: hi_byte  <= bus.i_load_byte;
          WORD_LO: word_idx <= word_idx + 16'd1;
          default: hi_byte  <= hi_byte;
        endcase
      end
    end
  end

  // LED register: memory-mapped write from the running CPU.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      led <= 16'h0000;
    end else if (cpu_write && (bus.i_ramaddr == LED_ADDR)) begin
      led <= bus.i_ram_data;
    end
  end

  // Instruction ROM and data RAM storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (rom_we) rom[word_idx[ROM_AW-1:0]] <= {hi_byte, bus.i_load_byte};
    if (cpu_write && ({1'b0, bus.i_ramaddr} < RAM_LIMIT)) begin
      ram[bus.i_ramaddr[RAM_AW-1:0]] <= bus.i_ram_data;
    end
  end

  // Data-side read mux: RAM, keyboard, LED readback, zero elsewhere.
  always_comb begin
    ram_rd = 16'h0000;
    if ({1'b0, bus.i_ramaddr} < RAM_LIMIT) ram_rd = ram[bus.i_ramaddr[RAM_AW-1:0]];
    else if (bus.i_ramaddr == KBD_ADDR)    ram_rd = bus.i_keyboard;
    else if (bus.i_ramaddr == LED_ADDR)    ram_rd = led;
    else                                   ram_rd = 16'h0000;
  end

  assign bus.o_instruction = ({1'b0, bus.i_pc} < ROM_LIMIT) ? rom[bus.i_pc[ROM_AW-1:0]] : 16'h0000;
  assign bus.o_ram         = ram_rd;
  assign bus.o_cpu_reset   = cpu_reset;
  assign bus.o_load_ready  = load_ready;
  assign bus.o_led         = led;
  assign bus.o_loaded      = loaded;
`ifdef HACK_MEM_LOAD_CHECKSUM_EN
  assign bus.o_load_error  = load_error;
`else
  assign bus.o_load_error  = 1'b0;
`endif
endmodule

// File: tb/tb_hack_memory.sv
// Directed bench for hack_memory: program loading, ROM/RAM/MMIO access, reload and reset corners.
// Built with or without HACK_MEM_LOAD_CHECKSUM_EN; checksum bytes are appended when it is defined.
module tb_hack_memory;
  localparam int ROM_D = 16;
  localparam int RAM_D = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hack_memory_if bus();

  hack_memory #(.ROM_DEPTH(ROM_D), .RAM_DEPTH(RAM_D)) dut (
    .clk    (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] exp_instr;
    logic [15:0] addr;
    logic [15:0] exp_ram;
  } vec_t;

  vec_t        vecs [8];
  logic [7:0]  stream [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int waits = 0;
    bus.i_load_valid = 1'b1;
    bus.i_load_byte  = b;
    while (!bus.o_load_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.o_load_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_ready_timeout: got 0, expected 1 for byte %h", b);
    end
    @(negedge clk);
    bus.i_load_valid = 1'b0;
  endtask

  task automatic send_stream();
    logic [7:0] x = 8'h00;
    foreach (stream[i]) begin
      x ^= stream[i];
      send_byte(stream[i]);
    end
`ifdef HACK_MEM_LOAD_CHECKSUM_EN
    send_byte(x);
`endif
    stream.delete();
  endtask

  task automatic load_prog_a();
    stream = '{8'h00, 8'h02, 8'h00, 8'h05, 8'hEC, 8'h10};
    send_stream();
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    bus.i_ramaddr    = a;
    bus.i_ram_data   = d;
    bus.i_ram_write  = 1'b1;
    @(negedge clk);
    bus.i_ram_write  = 1'b0;
  endtask

  task automatic pulse_reload();
    bus.i_reload = 1'b1;
    @(negedge clk);
    bus.i_reload = 1'b0;
  endtask

  task automatic read_instr(input string name, input logic [15:0] pc, input logic [15:0] exp);
    bus.i_pc = pc;
    #1;
    check(name, bus.o_instruction, exp);
  endtask

  initial begin
    vecs[0] = '{16'h0000, 16'h0005, 16'h0010, 16'hBEEF};
    vecs[1] = '{16'h0001, 16'hEC10, 16'h6000, 16'h0041};
    vecs[2] = '{16'h0010, 16'h0000, 16'h6001, 16'h00A5};
    vecs[3] = '{16'hFFFF, 16'h0000, 16'h7000, 16'h0000};
    vecs[4] = '{16'h0000, 16'h0005, 16'h0000, 16'h1111};
    vecs[5] = '{16'h0001, 16'hEC10, 16'h001F, 16'h2222};
    vecs[6] = '{16'h0011, 16'h0000, 16'h0020, 16'h0000};
    vecs[7] = '{16'h0001, 16'hEC10, 16'h6002, 16'h0000};

    bus.i_pc = 16'h0000; bus.i_ramaddr = 16'h0000; bus.i_ram_data = 16'h0000;
    bus.i_ram_write = 1'b0; bus.i_load_valid = 1'b0; bus.i_load_byte = 8'h00;
    bus.i_reload = 1'b0; bus.i_keyboard = 16'h0000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("reset_cpu_reset", {15'd0, bus.o_cpu_reset}, 16'd1);
    check("reset_load_ready", {15'd0, bus.o_load_ready}, 16'd1);
    check("reset_loaded", {15'd0, bus.o_loaded}, 16'd0);
    check("reset_led", bus.o_led, 16'h0000);
    check("reset_load_error", {15'd0, bus.o_load_error}, 16'd0);

    load_prog_a();
    check("loadA_loaded", {15'd0, bus.o_loaded}, 16'd1);
    check("loadA_cpu_reset", {15'd0, bus.o_cpu_reset}, 16'd0);
    check("loadA_ready", {15'd0, bus.o_load_ready}, 16'd0);

    cpu_write(16'h0010, 16'hBEEF);
    #1 check("ram_write_0010", bus.o_ram, 16'hBEEF);
    cpu_write(16'h6001, 16'h00A5);
    check("led_write", bus.o_led, 16'h00A5);
    cpu_write(16'h0000, 16'h1111);
    cpu_write(16'h001F, 16'h2222);
    cpu_write(16'h0020, 16'h3333);
    bus.i_keyboard = 16'h0041;

    for (int i = 0; i < 8; i++) begin
      bus.i_pc      = vecs[i].pc;
      bus.i_ramaddr = vecs[i].addr;
      #1;
      check($sformatf("vec%0d_instr", i), bus.o_instruction, vecs[i].exp_instr);
      check($sformatf("vec%0d_ram", i), bus.o_ram, vecs[i].exp_ram);
    end
    @(negedge clk);

    // Reload; CPU writes during loading must be discarded; a reload mid-load is ignored.
    pulse_reload();
    check("reload_cpu_reset", {15'd0, bus.o_cpu_reset}, 16'd1);
    check("reload_loaded", {15'd0, bus.o_loaded}, 16'd0);
    check("reload_ready", {15'd0, bus.o_load_ready}, 16'd1);
    cpu_write(16'h0010, 16'hDEAD);
    cpu_write(16'h6001, 16'hFFFF);
    bus.i_ramaddr = 16'h0010;
    #1 check("load_write_discard_ram", bus.o_ram, 16'hBEEF);
    check("load_write_discard_led", bus.o_led, 16'h00A5);
    send_byte(8'h00);
    pulse_reload();
    send_byte(8'h01);
    send_byte(8'hAB);
    send_byte(8'hCD);
`ifdef HACK_MEM_LOAD_CHECKSUM_EN
    send_byte(8'h67);
`endif
    check("reload_ignored_loaded", {15'd0, bus.o_loaded}, 16'd1);
    read_instr("partial_rom0", 16'h0000, 16'hABCD);
    read_instr("partial_rom1_kept", 16'h0001, 16'hEC10);

    // Empty program goes straight to RUN.
    pulse_reload();
    stream = '{8'h00, 8'h00};
    send_stream();
    check("n0_loaded", {15'd0, bus.o_loaded}, 16'd1);
    read_instr("n0_rom0_kept", 16'h0000, 16'hABCD);

    // One word more than the ROM holds: the extra word must not wrap onto rom[0].
    pulse_reload();
    stream.push_back(8'h00);
    stream.push_back(8'(ROM_D + 1));
    for (int k = 0; k <= ROM_D; k++) begin
      stream.push_back(8'h10);
      stream.push_back(8'(k));
    end
    send_stream();
    check("ovf_loaded", {15'd0, bus.o_loaded}, 16'd1);
    read_instr("ovf_rom0", 16'h0000, 16'h1000);
    read_instr("ovf_rom_last", 16'(ROM_D - 1), 16'h100F);

    // Reset in the middle of a load abandons it; a fresh load then works.
    pulse_reload();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_led", bus.o_led, 16'h0000);
    check("midrst_cpu_reset", {15'd0, bus.o_cpu_reset}, 16'd1);
    check("midrst_ready", {15'd0, bus.o_load_ready}, 16'd1);
    check("midrst_loaded", {15'd0, bus.o_loaded}, 16'd0);
    load_prog_a();
    check("midrst_reload_loaded", {15'd0, bus.o_loaded}, 16'd1);
    read_instr("midrst_rom0", 16'h0000, 16'h0005);
    read_instr("midrst_rom1", 16'h0001, 16'hEC10);

`ifdef HACK_MEM_LOAD_CHECKSUM_EN
    // Bad checksum lands in ERROR; reload with the correct one recovers.
    pulse_reload();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h00);
    check("csum_bad_error", {15'd0, bus.o_load_error}, 16'd1);
    check("csum_bad_cpu_reset", {15'd0, bus.o_cpu_reset}, 16'd1);
    check("csum_bad_ready", {15'd0, bus.o_load_ready}, 16'd0);
    pulse_reload();
    check("csum_reload_error_clr", {15'd0, bus.o_load_error}, 16'd0);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h27);
    check("csum_good_loaded", {15'd0, bus.o_loaded}, 16'd1);
    check("csum_good_error", {15'd0, bus.o_load_error}, 16'd0);
    read_instr("csum_good_rom0", 16'h0000, 16'h1234);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
